tlb_mport: RTL
==============

// Module: tlb_mport
// PURPOSE
// Parametrised LoongArch32 TLB: N-entry fully associative array, NSP registered search ports
// (fetch, load/store, TLBSRCH), registered read port, write port with TLBFILL index generator,
// and a multi-cycle INVTLB sweep engine. Sits beside csr in the CPU core; the pipeline
// stalls on inv_busy.
// PARAMETERS
// TLBNUM     16  entries (power of 2, 4..64); IDXW = $clog2(TLBNUM)
// NSP         2  search ports
// INV_LANES   4  entries invalidated per sweep cycle (divides TLBNUM)
// PORTS  (entry bus ENT[88:0] = {e,vppn[19],ps[6],asid[10],g,ppn0[20],plv0,mat0,d0,v0,ppn1[20],plv1,mat1,d1,v1})
// clk         in   1          clock; all logic rising-edge
// reset       in   1          synchronous, active-high
// s_req       in   NSP        search request per port
// s_vppn      in   NSP*19     VA[31:13] per port
// s_va_bit12  in   NSP        VA[12] per port
// s_asid      in   NSP*10     ASID per port
// s_rvalid    out  NSP        result valid, 1 cycle after s_req
// s_found     out  NSP        hit
// s_index     out  NSP*IDXW   hit entry index
// s_page      out  NSP*32    {ppn[20],ps[6],plv[2],mat[2],d,v} of selected half-page
// r_req/r_index  in 1/IDXW    read request / index
// r_rvalid/r_entry out 1/89   read data, 1 cycle after r_req
// we/w_fill   in   1/1        write enable / use fill index instead of w_index
// w_index/w_entry in IDXW/89  write index / entry
// fill_index  out  IDXW       index TLBFILL will use this cycle
// inv_req     in   1          start INVTLB; inv_op[5], inv_asid[10], inv_vppn[19] sampled with it
// inv_busy    out  1          sweep in progress
// inv_done    out  1          1-cycle pulse on sweep completion
// BEHAVIOUR
// - Reset: all e bits 0; every output 0; fill counter 0; FSM IDLE. Other array fields unreset.
// - Search hit on entry i: e & (g | asid==s_asid) & (ps==21 ? vppn[18:9]==s_vppn[18:9]
//   : vppn==s_vppn). Odd-page select = ps==21 ? s_vppn[8] : s_va_bit12.
// - Search registered: s_rvalid(t+1)=s_req(t); found/index/page reflect array at t (before a
//   write at t). Multiple hits = software error: lowest index wins. Miss: index/page 0.
// - Outputs hold last result while s_req low; ports independent, same-entry searches legal.
// - Read: r_entry(t+1)=array[r_index](t); write at t not forwarded.
// - Write: we at t updates entry at t+1 edge; index = w_fill ? fill_index : w_index.
// - fill_index: free-running counter, +1 each cycle, wraps TLBNUM-1 -> 0.
// - INVTLB FSM IDLE -> SWEEP (on inv_req) -> IDLE. SWEEP: lane group k clears e of matching
//   entries in [k*INV_LANES, (k+1)*INV_LANES); TLBNUM/INV_LANES cycles; inv_done pulses in
//   last SWEEP cycle; inv_busy high whole SWEEP.
// - inv_op: 0/1 all; 2 g=1; 3 g=0; 4 g=0&asid; 5 g=0&asid&va; 6 (g|asid)&va; va match per
//   ps rule above. op>6: no sweep, inv_done pulses next cycle, no entry changed.
// - During SWEEP: inv_req, we ignored; searches/reads allowed and see partially swept array.
// - Write and sweep clearing same entry same cycle: impossible (we ignored).
// - reset mid-sweep: FSM to IDLE, inv_busy/inv_done 0, all e cleared.
// TESTING
// - Write idx3 {e=1,vppn=0x12345,ps=12,asid=5,g=0,ppn0=0xAAAAA,ppn1=0xBBBBB,v0=v1=1};
//   search port0 vppn=0x12345,bit12=1,asid=5 -> next cycle found=1,index=3,ppn=0xBBBBB.
// - Same entry, asid=6 -> found=0; rewrite g=1 -> found=1 for any asid, both ports same cycle.
// - 4MB entry ps=21 vppn=0x40000 idx7; search vppn=0x401FF -> hit, odd page (bit8=1).
// - inv_op=5 asid=5 va=0x12345 with TLBNUM=16,INV_LANES=4 -> inv_busy 4 cycles, done pulse,
//   idx3 e=0, g=1 entries untouched.
// - 20 w_fill writes back-to-back -> indices wrap 15->0; read back each via r_req, 1-cycle latency.
// - reset asserted in sweep cycle 2 -> next cycle inv_busy=0, all searches miss.

Source files
------------

// File: rtl/tlb_mport.sv
// LoongArch32 TLB: fully associative entry array with registered search ports,
// a registered read port, a write port with a free-running TLBFILL index,
// and a multi-cycle INVTLB sweep engine that clears INV_LANES entries per cycle.
module tlb_mport #(
    parameter int TLBNUM    = 16,
    parameter int NSP       = 2,
    parameter int INV_LANES = 4,
    localparam int IDXW     = $clog2(TLBNUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSP-1:0]        s_req,
    input  logic [NSP*19-1:0]     s_vppn,
    input  logic [NSP-1:0]        s_va_bit12,
    input  logic [NSP*10-1:0]     s_asid,
    output logic [NSP-1:0]        s_rvalid,
    output logic [NSP-1:0]        s_found,
    output logic [NSP*IDXW-1:0]   s_index,
    output logic [NSP*32-1:0]     s_page,
    input  logic                  r_req,
    input  logic [IDXW-1:0]       r_index,
    output logic                  r_rvalid,
    output logic [88:0]           r_entry,
    input  logic                  we,
    input  logic                  w_fill,
    input  logic [IDXW-1:0]       w_index,
    input  logic [88:0]           w_entry,
    output logic [IDXW-1:0]       fill_index,
    input  logic                  inv_req,
    input  logic [4:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_vppn,
    output logic                  inv_busy,
    output logic                  inv_done
);

    localparam int NGRP = TLBNUM / INV_LANES;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [5:0] PS_4M = 6'd21;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_NOP} inv_state_e;

    // Entry fields below bit 88 share the bus layout; the e bit lives apart so it can be reset.
    logic              e_q   [TLBNUM];
    logic              e_d   [TLBNUM];
    logic [87:0]       ent_q [TLBNUM];
    logic [87:0]       ent_d [TLBNUM];

    logic [IDXW-1:0]   fill_q, fill_d;
    inv_state_e        state_q, state_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic [4:0]        op_q, op_d;
    logic [9:0]        asid_q, asid_d;
    logic [18:0]       vppn_q, vppn_d;

    logic [NSP-1:0]      s_rvalid_q, s_rvalid_d;
    logic [NSP-1:0]      s_found_q, s_found_d;
    logic [NSP*IDXW-1:0] s_index_q, s_index_d;
    logic [NSP*32-1:0]   s_page_q, s_page_d;
    logic                r_rvalid_q, r_rvalid_d;
    logic [88:0]         r_entry_q, r_entry_d;

    logic                wr_en;
    logic [IDXW-1:0]     wr_idx;

    function automatic logic va_hit(input logic [87:0] ent, input logic [18:0] vppn);
        if (ent[68:63] == PS_4M) return ent[87:78] == vppn[18:9];
        return ent[87:69] == vppn;
    endfunction

    function automatic logic [31:0] page_of(input logic [87:0] ent, input logic odd);
        if (odd) return {ent[25:6], ent[68:63], ent[5:0]};
        return {ent[51:32], ent[68:63], ent[31:26]};
    endfunction

    function automatic logic inv_hit(input logic [87:0] ent, input logic [4:0] op,
                                     input logic [9:0] asid, input logic [18:0] vppn);
        logic g, am, vm;
        g  = ent[52];
        am = (ent[62:53] == asid);
        vm = va_hit(ent, vppn);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return g;
            5'd3:       return !g;
            5'd4:       return !g && am;
            5'd5:       return !g && am && vm;
            5'd6:       return (g || am) && vm;
            default:    return 1'b0;
        endcase
    endfunction

    assign wr_en  = we && (state_q != ST_SWEEP);
    assign wr_idx = w_fill ? fill_q : w_index;
    assign fill_d = fill_q + 1'b1;

    // Array next state: accepted writes, plus sweep clearing of the current lane group
    always_comb begin
        ent_d = ent_q;
        e_d   = e_q;
        if (wr_en) begin
            ent_d[wr_idx] = w_entry[87:0];
            e_d[wr_idx]   = w_entry[88];
        end
        if (state_q == ST_SWEEP) begin
            for (int unsigned j = 0; j < TLBNUM; j++) begin
                if (GW'(j / INV_LANES) == grp_q && inv_hit(ent_q[j], op_q, asid_q, vppn_q))
                    e_d[j] = 1'b0;
            end
        end
    end

    // INVTLB sequencer: latch operands, step lane groups, pulse done on the last one
    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        op_d     = op_q;
        asid_d   = asid_q;
        vppn_d   = vppn_q;
        inv_busy = 1'b0;
        inv_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inv_req) begin
                    op_d    = inv_op;
                    asid_d  = inv_asid;
                    vppn_d  = inv_vppn;
                    grp_d   = '0;
                    state_d = (inv_op > 5'd6) ? ST_NOP : ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                inv_busy = 1'b1;
                if (grp_q == GW'(NGRP - 1)) begin
                    inv_done = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            ST_NOP: begin
                inv_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Search ports: lowest-index hit wins; results hold while a port is idle
    always_comb begin
        s_rvalid_d = s_req;
        s_found_d  = s_found_q;
        s_index_d  = s_index_q;
        s_page_d   = s_page_q;
        for (int unsigned p = 0; p < NSP; p++) begin
            if (s_req[p]) begin
                s_found_d[p]               = 1'b0;
                s_index_d[p*IDXW +: IDXW]  = '0;
                s_page_d[p*32 +: 32]       = '0;
                for (int unsigned i = 0; i < TLBNUM; i++) begin
                    if (!s_found_d[p] && e_q[i]
                        && (ent_q[i][52] || ent_q[i][62:53] == s_asid[p*10 +: 10])
                        && va_hit(ent_q[i], s_vppn[p*19 +: 19])) begin
                        s_found_d[p]              = 1'b1;
                        s_index_d[p*IDXW +: IDXW] = IDXW'(i);
                        s_page_d[p*32 +: 32]      = page_of(ent_q[i],
                            (ent_q[i][68:63] == PS_4M) ? s_vppn[p*19 + 8] : s_va_bit12[p]);
                    end
                end
            end
        end
    end

    // Read port: capture the addressed entry, hold while idle
    always_comb begin
        r_rvalid_d = r_req;
        r_entry_d  = r_req ? {e_q[r_index], ent_q[r_index]} : r_entry_q;
    end

    // Control and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < TLBNUM; i++) e_q[i] <= 1'b0;
            fill_q     <= '0;
            state_q    <= ST_IDLE;
            grp_q      <= '0;
            op_q       <= '0;
            asid_q     <= '0;
            vppn_q     <= '0;
            s_rvalid_q <= '0;
            s_found_q  <= '0;
            s_index_q  <= '0;
            s_page_q   <= '0;
            r_rvalid_q <= 1'b0;
            r_entry_q  <= '0;
        end else begin
            e_q        <= e_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            grp_q      <= grp_d;
            op_q       <= op_d;
            asid_q     <= asid_d;
            vppn_q     <= vppn_d;
            s_rvalid_q <= s_rvalid_d;
            s_found_q  <= s_found_d;
            s_index_q  <= s_index_d;
            s_page_q   <= s_page_d;
            r_rvalid_q <= r_rvalid_d;
            r_entry_q  <= r_entry_d;
        end
    end

    // Entry payload storage, not reset
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign fill_index = fill_q;
    assign s_rvalid   = s_rvalid_q;
    assign s_found    = s_found_q;
    assign s_index    = s_index_q;
    assign s_page     = s_page_q;
    assign r_rvalid   = r_rvalid_q;
    assign r_entry    = r_entry_q;

endmodule
